// File: rtl/wide_add_sequencer.sv
// Drives one shared WIDTH-bit adder word by word (LSW first) to build a WIDTH*WORDS-bit sum.
// Define WIDE_ADD_SUB_EN to add a 'sub' port that turns the operation into op_a - op_b.
module wide_add_sequencer #(
   parameter int WIDTH = 16,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic [WIDTH*WORDS-1:0] op_a,
   input  logic [WIDTH*WORDS-1:0] op_b,
   input  logic                   c_in,
`ifdef WIDE_ADD_SUB_EN
   input  logic                   sub,
`endif
   output logic                   done_valid,
   input  logic                   done_ready,
   output logic [WIDTH*WORDS-1:0] result,
   output logic                   c_out,
   output logic                   busy,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_cin,
   input  logic [WIDTH-1:0]       add_sum,
   input  logic                   add_cout
);

   localparam int TOTAL = WIDTH * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [TOTAL-1:0] a_reg;
   logic [TOTAL-1:0] b_reg;
   logic             carry_reg;
   logic [TOTAL-1:0] b_load;
   logic             carry_load;

   // Subtraction is a + ~b + 1, so only the loaded B word and initial carry differ.
   always_comb begin
`ifdef WIDE_ADD_SUB_EN
      b_load     = sub ? ~op_b : op_b;
      carry_load = sub ? 1'b1 : c_in;
`else
      b_load     = op_b;
      carry_load = c_in;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         result    <= '0;
         c_out     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  a_reg     <= op_a;
                  b_reg     <= b_load;
                  carry_reg <= carry_load;
                  result    <= '0;
                  idx       <= '0;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               result[idx*WIDTH +: WIDTH] <= add_sum;
               carry_reg                  <= add_cout;
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  c_out <= add_cout;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               if (done_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == S_RUN) begin
         add_a   = a_reg[idx*WIDTH +: WIDTH];
         add_b   = b_reg[idx*WIDTH +: WIDTH];
         add_cin = carry_reg;
      end
   end

   assign start_ready = (state == S_IDLE);
   assign done_valid  = (state == S_DONE);
   assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: vector table, hand-written corner
// sequences and random operands against an arithmetic reference model.
module tb_wide_add_sequencer;

   localparam int W = 16;
   localparam int N = 4;
   localparam int T = W * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_valid = 1'b0;
   logic          c_in = 1'b0;
   logic          done_ready = 1'b1;
   logic [T-1:0]  op_a = '0;
   logic [T-1:0]  op_b = '0;
`ifdef WIDE_ADD_SUB_EN
   logic          sub = 1'b0;
`endif
   logic          start_ready;
   logic          done_valid;
   logic [T-1:0]  result;
   logic          c_out;
   logic          busy;
   logic [W-1:0]  add_a;
   logic [W-1:0]  add_b;
   logic          add_cin;
   logic [W-1:0]  add_sum;
   logic          add_cout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Stand-in for the external combinational 16-bit adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

   wide_add_sequencer #(.WIDTH(W), .WORDS(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .c_in       (c_in),
`ifdef WIDE_ADD_SUB_EN
      .sub        (sub),
`endif
      .done_valid (done_valid),
      .done_ready (done_ready),
      .result     (result),
      .c_out      (c_out),
      .busy       (busy),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_cin    (add_cin),
      .add_sum    (add_sum),
      .add_cout   (add_cout)
   );

   typedef struct {
      logic [T-1:0] a;
      logic [T-1:0] b;
      logic         cin;
      logic         s;
      logic [T-1:0] er;
      logic         ec;
   } vec_t;

   task automatic check(input string name, input logic [T:0] act, input logic [T:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {c_out, result} from the arithmetic definition of the operation.
   function automatic logic [T:0] model(input logic [T-1:0] a, input logic [T-1:0] b,
                                        input logic cin, input logic s);
      if (s) return {a >= b, a - b};
      return {1'b0, a} + {1'b0, b} + (T+1)'(cin);
   endfunction

   // Carry entering word k = carry out of the low k words of the full operation.
   function automatic logic carry_into(input logic [T-1:0] a, input logic [T-1:0] b,
                                       input logic cin, input logic s, input int k);
      logic [T:0] m;
      logic [T:0] am;
      logic [T:0] bm;
      logic [T:0] sm;
      m  = ((T+1)'(1) << (W*k)) - (T+1)'(1);
      am = {1'b0, a} & m;
      bm = {1'b0, b} & m;
      if (s) return am >= bm;
      sm = am + bm + (T+1)'(cin);
      return sm[W*k];
   endfunction

   task automatic wait_ready();
      for (int k = 0; k < 40 && !start_ready; k++) tick();
      check("start_ready_wait", start_ready, 1);
   endtask

   task automatic drive_op(input logic [T-1:0] a, input logic [T-1:0] b,
                           input logic cin, input logic s);
      op_a = a;
      op_b = b;
      c_in = cin;
`ifdef WIDE_ADD_SUB_EN
      sub = s;
`endif
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (!done_valid && cyc < N + 6) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, cyc, N);
   endtask

   task automatic run_op(input logic [T-1:0] a, input logic [T-1:0] b, input logic cin,
                         input logic s, input logic [T-1:0] er, input logic ec,
                         input string tag);
      logic [T-1:0] be;
      int           cyc;
      be = s ? ~b : b;
      wait_ready();
      drive_op(a, b, cin, s);
      start_valid = 1'b1;
      done_ready  = 1'b1;
      tick();
      start_valid = 1'b0;
      drive_op(~a, ~b, ~cin, ~s);
      check({tag, "_accept_busy"}, busy, 1);
      check({tag, "_accept_ready"}, start_ready, 0);
      check({tag, "_accept_clear"}, result, 0);
      cyc = 0;
      while (!done_valid && cyc < N + 6) begin
         if (cyc < N) begin
            check($sformatf("%s_add_a%0d", tag, cyc), add_a, a[cyc*W +: W]);
            check($sformatf("%s_add_b%0d", tag, cyc), add_b, be[cyc*W +: W]);
            check($sformatf("%s_add_cin%0d", tag, cyc), add_cin, carry_into(a, b, cin, s, cyc));
         end
         tick();
         cyc++;
      end
      check({tag, "_latency"}, cyc, N);
      check({tag, "_result"}, result, er);
      check({tag, "_c_out"}, c_out, ec);
      check({tag, "_adder_idle"}, {add_a, add_b, add_cin}, 0);
      check({tag, "_done_busy"}, busy, 1);
      tick();
      check({tag, "_post_done_valid"}, done_valid, 0);
      check({tag, "_post_ready"}, start_ready, 1);
      check({tag, "_hold_result"}, {c_out, result}, {ec, er});
   endtask

   initial begin
      vec_t         vecs[$];
      vec_t         v;
      logic [T-1:0] ra;
      logic [T-1:0] rb;
      logic         rc;
      logic         rs;
      logic [T:0]   exp;
      int           seen;

      v = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
      vecs.push_back(v);
      v = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1};
      vecs.push_back(v);
      v = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
            64'h2222_2222_2222_2212, 1'b0};
      vecs.push_back(v);
      v = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0};
      vecs.push_back(v);
      v = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs.push_back(v);
`ifdef WIDE_ADD_SUB_EN
      v = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs.push_back(v);
      v = '{64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1};
      vecs.push_back(v);
      v = '{64'h7, 64'h5, 1'b0, 1'b0, 64'hC, 1'b0};
      vecs.push_back(v);
`endif

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_start_ready", start_ready, 1);
      check("rst_done_valid", done_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", {c_out, result}, 0);
      check("rst_adder", {add_a, add_b, add_cin}, 0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i])
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].er, vecs[i].ec,
                $sformatf("vec%0d", i));

      // Done stalled with start_valid held: start waits for the done handshake.
      wait_ready();
      drive_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
      start_valid = 1'b1;
      done_ready  = 1'b0;
      tick();
      drive_op(64'd100, 64'd23, 1'b0, 1'b0);
      wait_done("stall");
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall_done_valid%0d", i), done_valid, 1);
         check($sformatf("stall_result%0d", i), {c_out, result}, {1'b0, 64'h2222_2222_2222_2212});
         check($sformatf("stall_ready%0d", i), start_ready, 0);
         tick();
      end
      check("stall_still_done", done_valid, 1);
      done_ready = 1'b1;
      tick();
      check("handshake_idle", start_ready, 1);
      check("handshake_done_low", done_valid, 0);
      check("handshake_busy", busy, 0);
      tick();
      check("next_accept_busy", busy, 1);
      check("next_accept_clear", result, 0);
      start_valid = 1'b0;
      wait_done("second");
      check("second_result", {c_out, result}, {1'b0, 64'd123});
      tick();

      // Reset after two words aborts the operation.
      wait_ready();
      drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_ready", start_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done_valid, 0);
      check("abort_result", {c_out, result}, 0);
      check("abort_adder", {add_a, add_b, add_cin}, 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done_valid) seen++;
      end
      check("abort_no_done", seen, 0);

      // Random operands against the reference model.
      for (int i = 0; i < 25; i++) begin
         ra = {$urandom, $urandom};
         rb = (i % 4 == 0) ? ~ra : {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
`ifdef WIDE_ADD_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         exp = model(ra, rb, rc, rs);
         run_op(ra, rb, rc, rs, exp[T-1:0], exp[T], $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs WORDS*WIDTH-bit additions on one external parallel_carry_adder_16bit instance, one WIDTH-bit word per cycle, LSW first.
- Carry-out of each word chains into the carry-in of the next.
- Sits between a requester (start handshake) and a consumer (done handshake); owns the shared adder's operand and carry inputs.

Parameters:
WIDTH, 16, word width; must equal adder width.
WORDS, 4, number of words per operand; must be >= 1 (default gives 64-bit operands).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
start_valid  input  1  requester presents operands.
start_ready  output  1  block can accept; high only in IDLE.
op_a  input  WIDTH*WORDS  operand A, sampled on accept.
op_b  input  WIDTH*WORDS  operand B, sampled on accept.
c_in  input  1  initial carry, sampled on accept.
done_valid  output  1  result and c_out valid; high only in DONE.
done_ready  input  1  consumer accepts result.
result  output  WIDTH*WORDS  registered sum.
c_out  output  1  registered final carry.
busy  output  1  high in RUN or DONE.
add_a  output  WIDTH  to adder a.
add_b  output  WIDTH  to adder b.
add_cin  output  1  to adder c_in.
add_sum  input  WIDTH  from adder sum.
add_cout  input  1  from adder c_out.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; idx, a_reg, b_reg, carry_reg, result, c_out all 0.
  - done_valid=0, busy=0, start_ready=1.
  - Reset mid-RUN or mid-DONE aborts the operation; no done is issued.
- FSM states IDLE, RUN, DONE:
  - IDLE: start_ready=1. On start_valid, latch op_a, op_b and c_in (into carry_reg), clear result, set idx=0, go to RUN.
  - RUN: add_a = a_reg word[idx], add_b = b_reg word[idx], add_cin = carry_reg, all driven from registers only. Each cycle: result word[idx] <= add_sum, carry_reg <= add_cout, idx <= idx+1. At the edge where idx==WORDS-1: c_out <= add_cout, go to DONE.
  - DONE: done_valid=1; result and c_out are held stable. On done_ready, go to IDLE.
- Adder port drive: add_a, add_b and add_cin are 0 in IDLE and DONE. The adder is treated as purely combinational within one cycle.
- Latency: accept at edge T; words captured at edges T+1..T+WORDS; done_valid high from T+WORDS (after that edge). Minimum period between accepts is WORDS+2 cycles with done_ready tied high.
- WORDS=1: a single RUN cycle, then DONE.
- Overlapping handshakes:
  - start_valid outside IDLE is ignored; the requester must hold it until it sees start_ready.
  - A done handshake and a new start_valid in the same cycle: only the done handshake completes; the start is accepted on the next cycle in IDLE.
- Stability:
  - result and c_out keep their last value in IDLE until the next accept clears result.
  - op_a and op_b may change freely after accept.
- Arithmetic: {c_out,result} = op_a + op_b + c_in, modulo 2^(WIDTH*WORDS+1).

Optional Feature:
- Macro: WIDE_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on accept.
  - When sub=1: b_reg latches ~op_b and carry_reg latches 1; c_in is ignored. result = op_a - op_b mod 2^(WIDTH*WORDS), and c_out=1 means no borrow (op_a >= op_b).
  - When sub=0: identical to the base add behaviour.
- Undefined: no sub port; add only.

Test Plan (WORDS=4, WIDTH=16, reference model alongside):
1. a=0x0000_0000_0000_FFFF, b=0x1, c_in=0, done_ready=1 -> result=0x0000_0000_0001_0000, c_out=0; done_valid rises exactly 4 edges after accept; add_cin=1 during word 1.
2. a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, c_in=0 -> result=0x0, c_out=1; carry propagates through all 4 words.
3. a=0x1234_5678_9ABC_DEF0, b=0x0FED_CBA9_8765_4321, c_in=1 -> result=0x2222_2222_2222_2212, c_out=0.
4. done_ready held 0 for 3 cycles after done_valid, with start_valid=1 throughout -> done_valid stays 1, result and c_out stay stable, start_ready=0; new accept occurs exactly 1 cycle after the done handshake.
5. rst_n pulsed low for one edge after 2 words in RUN -> next cycle: state IDLE, result=0, c_out=0, busy=0, done_valid=0, adder inputs 0; no done_valid is ever issued for the aborted operation.
6. WIDE_ADD_SUB_EN defined:
   - a=5, b=7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, c_out=0.
   - a=7, b=5, sub=1 -> result=0x2, c_out=1.
   - a=7, b=5, sub=0, c_in=0 -> result=0xC, c_out=0.
